// File: rtl/axi_pkg.sv
// Shared AXI definitions for the write master.
//   - Response codes (OKAY/EXOKAY/SLVERR/DECERR)
//   - Burst codes (FIXED/INCR/WRAP)
//   - Write-master FSM state encoding
//   - Error counter saturation value
package axi_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axi_resp_e;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } axi_burst_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ADDR = 2'b01,
    DATA = 2'b10
  } wr_state_e;

  localparam logic [7:0] ERR_CNT_MAX = 8'hFF;

endpackage

// File: rtl/axi_rsp_reg.sv
// Single-entry register between the AXI B channel and the requester's
// response port.
//   clk, rst_n        clock, asynchronous active-low reset
//   in_valid_i/in_ready_o/in_id_i/in_resp_i     B channel side
//   out_valid_o/out_ready_i/out_id_o/out_resp_o requester side
// Accepts a new entry whenever it is empty or being drained in the same
// cycle, so a steady stream of B beats passes at full rate.
module axi_rsp_reg #(
  parameter int unsigned ID_W = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [ID_W-1:0] in_id_i,
  input  logic [1:0]      in_resp_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [ID_W-1:0] out_id_o,
  output logic [1:0]      out_resp_o
);

  logic            valid_q;
  logic [ID_W-1:0] id_q;
  logic [1:0]      resp_q;

  assign in_ready_o  = !valid_q || out_ready_i;
  assign out_valid_o = valid_q;
  assign out_id_o    = id_q;
  assign out_resp_o  = resp_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of evaluation order between always blocks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: payload flops are reset as well (not only the valid bit) so the
      // outputs are deterministic out of reset; a RAM would not be cleared.
      valid_q <= 1'b0;
      id_q    <= '0;
      resp_q  <= '0;
    end else if (in_valid_i && in_ready_o) begin
      valid_q <= 1'b1;
      id_q    <= in_id_i;
      resp_q  <= in_resp_i;
    end else if (out_ready_i) begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/axi_wr_master.sv
// AXI write-channel master: converts a command + write-data stream into
// AW/W traffic and returns B responses to the requester.
//   a_clk, a_resetn                 clock, asynchronous active-low reset
//   cmd_*                           command in (id/addr/len/size/burst)
//   wd_*                            write data beats in
//   aw_*, w_*, b_*                  AXI write address/data/response channels
//   rsp_*                           registered B response to the requester
//   outst_cnt                       AW handshakes not yet matched by a B
//   err_cnt                         non-OKAY B responses, saturating
// Transactions are issued strictly in order, one burst at a time: AW first,
// then its W beats, then the next command may be taken.
module axi_wr_master
  import axi_pkg::*;
#(
  parameter int unsigned MAX_OUTST = 4,
  parameter int unsigned ID_W      = 4,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32
) (
  input  logic                a_clk,
  input  logic                a_resetn,
  // command
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [ID_W-1:0]     cmd_id,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [3:0]          cmd_len,
  input  logic [2:0]          cmd_size,
  input  logic [1:0]          cmd_burst,
  // write data stream
  input  logic                wd_valid,
  output logic                wd_ready,
  input  logic [DATA_W-1:0]   wd_data,
  input  logic [DATA_W/8-1:0] wd_strb,
  // AW channel
  output logic [ID_W-1:0]     aw_id,
  output logic [ADDR_W-1:0]   aw_addr,
  output logic [3:0]          aw_len,
  output logic [2:0]          aw_size,
  output logic [1:0]          aw_burst,
  output logic                aw_valid,
  input  logic                aw_ready,
  // W channel
  output logic [ID_W-1:0]     w_id,
  output logic [DATA_W-1:0]   w_data,
  output logic [DATA_W/8-1:0] w_strb,
  output logic                w_last,
  output logic                w_valid,
  input  logic                w_ready,
  // B channel
  input  logic [ID_W-1:0]     b_id,
  input  logic [1:0]          b_resp,
  input  logic                b_valid,
  output logic                b_ready,
  // response to requester
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [ID_W-1:0]     rsp_id,
  output logic [1:0]          rsp_resp,
  // status
  output logic [3:0]          outst_cnt,
  output logic [7:0]          err_cnt
);

  localparam logic [3:0] MAX_OUTST_C = 4'(MAX_OUTST);

  wr_state_e         state_q;
  logic [ID_W-1:0]   aw_id_q;
  logic [ADDR_W-1:0] aw_addr_q;
  logic [3:0]        aw_len_q;
  logic [2:0]        aw_size_q;
  logic [1:0]        aw_burst_q;
  logic              aw_valid_q;
  logic [ID_W-1:0]   w_id_q;
  logic [3:0]        beat_cnt_q;
  logic              cmd_ready_q;
  logic [3:0]        outst_q, outst_d;
  logic [7:0]        err_q;

  logic in_data;
  logic cmd_hs, aw_hs, w_hs, b_hs;
  logic idle_next;

  assign in_data = (state_q == DATA);
  assign cmd_hs  = cmd_valid && cmd_ready_q;
  assign aw_hs   = aw_valid_q && aw_ready;
  assign w_hs    = w_valid && w_ready;
  assign b_hs    = b_valid && b_ready;

  // W beats pass straight through while the current burst's AW is done.
  assign w_valid  = in_data && wd_valid;
  assign wd_ready = in_data && w_ready;
  assign w_data   = wd_data;
  assign w_strb   = wd_strb;
  assign w_id     = w_id_q;
  assign w_last   = in_data && (beat_cnt_q == 4'd0);

  assign aw_id     = aw_id_q;
  assign aw_addr   = aw_addr_q;
  assign aw_len    = aw_len_q;
  assign aw_size   = aw_size_q;
  assign aw_burst  = aw_burst_q;
  assign aw_valid  = aw_valid_q;
  assign cmd_ready = cmd_ready_q;
  assign outst_cnt = outst_q;
  assign err_cnt   = err_q;

  // The FSM sits in IDLE after this edge either by staying there without a
  // command or by finishing the last beat of the current burst.
  assign idle_next = ((state_q == IDLE) && !cmd_hs) ||
                     (in_data && w_hs && (beat_cnt_q == 4'd0));

  // A B arriving with nothing outstanding is forwarded but cannot push the
  // count below zero; simultaneous AW and B cancel out.
  always_comb begin
    // NOTE: default assignment first so every path drives outst_d and no
    // latch is inferred.
    outst_d = outst_q;
    if (aw_hs && !b_hs) begin
      outst_d = outst_q + 4'd1;
    end else if (b_hs && !aw_hs && (outst_q != 4'd0)) begin
      outst_d = outst_q - 4'd1;
    end
  end

  always_ff @(posedge a_clk or negedge a_resetn) begin
    if (!a_resetn) begin
      state_q     <= IDLE;
      aw_id_q     <= '0;
      aw_addr_q   <= '0;
      aw_len_q    <= '0;
      aw_size_q   <= '0;
      aw_burst_q  <= '0;
      aw_valid_q  <= 1'b0;
      w_id_q      <= '0;
      beat_cnt_q  <= '0;
      cmd_ready_q <= 1'b0;
    end else begin
      // Registered so cmd_ready already reflects the count after this edge.
      cmd_ready_q <= idle_next && (outst_d < MAX_OUTST_C);
      case (state_q)
        IDLE: begin
          if (cmd_hs) begin
            aw_id_q    <= cmd_id;
            aw_addr_q  <= cmd_addr;
            aw_len_q   <= cmd_len;
            aw_size_q  <= cmd_size;
            aw_burst_q <= cmd_burst;
            w_id_q     <= cmd_id;
            beat_cnt_q <= cmd_len;
            aw_valid_q <= 1'b1;
            state_q    <= ADDR;
          end
        end
        ADDR: begin
          if (aw_ready) begin
            aw_valid_q <= 1'b0;
            state_q    <= DATA;
          end
        end
        DATA: begin
          if (w_hs) begin
            if (beat_cnt_q == 4'd0) begin
              state_q <= IDLE;
            end else begin
              beat_cnt_q <= beat_cnt_q - 4'd1;
            end
          end
        end
        default: begin
          aw_valid_q <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge a_clk or negedge a_resetn) begin
    if (!a_resetn) begin
      outst_q <= '0;
      err_q   <= '0;
    end else begin
      outst_q <= outst_d;
      if (b_hs && (b_resp != RESP_OKAY) && (err_q != ERR_CNT_MAX)) begin
        err_q <= err_q + 8'd1;
      end
    end
  end

  axi_rsp_reg #(
    .ID_W (ID_W)
  ) u_rsp_reg (
    .clk         (a_clk),
    .rst_n       (a_resetn),
    .in_valid_i  (b_valid),
    .in_ready_o  (b_ready),
    .in_id_i     (b_id),
    .in_resp_i   (b_resp),
    .out_valid_o (rsp_valid),
    .out_ready_i (rsp_ready),
    .out_id_o    (rsp_id),
    .out_resp_o  (rsp_resp)
  );

endmodule

// File: tb/tb_axi_wr_master.sv
// Self-checking bench for axi_wr_master. A transaction-level model (command
// queue, burst/beat indices, counters, one pending response) predicts the
// DUT outputs every cycle; directed scenarios add literal expectations.
module tb_axi_wr_master;
  import axi_pkg::*;

  localparam int MAX_OUTST = 4;
  localparam int BOUND     = 50;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [3:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } cmd_t;

  logic        a_clk = 1'b0;
  logic        a_resetn = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready;
  logic [3:0]  cmd_id = '0;
  logic [31:0] cmd_addr = '0;
  logic [3:0]  cmd_len = '0;
  logic [2:0]  cmd_size = '0;
  logic [1:0]  cmd_burst = '0;
  logic        wd_valid = 1'b0, wd_ready;
  logic [31:0] wd_data = '0;
  logic [3:0]  wd_strb = '0;
  logic [3:0]  aw_id;
  logic [31:0] aw_addr;
  logic [3:0]  aw_len;
  logic [2:0]  aw_size;
  logic [1:0]  aw_burst;
  logic        aw_valid, aw_ready = 1'b1;
  logic [3:0]  w_id;
  logic [31:0] w_data;
  logic [3:0]  w_strb;
  logic        w_last, w_valid, w_ready = 1'b1;
  logic [3:0]  b_id = '0;
  logic [1:0]  b_resp = '0;
  logic        b_valid = 1'b0, b_ready;
  logic        rsp_valid, rsp_ready = 1'b1;
  logic [3:0]  rsp_id;
  logic [1:0]  rsp_resp;
  logic [3:0]  outst_cnt;
  logic [7:0]  err_cnt;

  axi_wr_master #(
    .MAX_OUTST (MAX_OUTST),
    .ID_W      (4),
    .ADDR_W    (32),
    .DATA_W    (32)
  ) dut (
    .a_clk     (a_clk),     .a_resetn  (a_resetn),
    .cmd_valid (cmd_valid), .cmd_ready (cmd_ready), .cmd_id (cmd_id),
    .cmd_addr  (cmd_addr),  .cmd_len   (cmd_len),   .cmd_size (cmd_size),
    .cmd_burst (cmd_burst),
    .wd_valid  (wd_valid),  .wd_ready  (wd_ready),  .wd_data (wd_data),
    .wd_strb   (wd_strb),
    .aw_id     (aw_id),     .aw_addr   (aw_addr),   .aw_len  (aw_len),
    .aw_size   (aw_size),   .aw_burst  (aw_burst),  .aw_valid (aw_valid),
    .aw_ready  (aw_ready),
    .w_id      (w_id),      .w_data    (w_data),    .w_strb  (w_strb),
    .w_last    (w_last),    .w_valid   (w_valid),   .w_ready (w_ready),
    .b_id      (b_id),      .b_resp    (b_resp),    .b_valid (b_valid),
    .b_ready   (b_ready),
    .rsp_valid (rsp_valid), .rsp_ready (rsp_ready), .rsp_id  (rsp_id),
    .rsp_resp  (rsp_resp),
    .outst_cnt (outst_cnt), .err_cnt   (err_cnt)
  );

  always #5 a_clk = ~a_clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model state ----------------
  cmd_t        cmd_q[$];
  int          aw_idx, burst_idx, beat_idx;
  int          exp_outst, exp_err;
  logic        exp_rv;
  logic [3:0]  exp_rid;
  logic [1:0]  exp_rresp;
  logic        prev_aw_stall;
  cmd_t        prev_aw;
  int          w_hs_total, w_last_total;
  logic [31:0] last_w_data;
  logic        last_w_last;
  logic [3:0]  last_w_id;
  logic [3:0]  rsp_id_log[$];
  logic [1:0]  rsp_resp_log[$];

  initial begin
    aw_idx = 0; burst_idx = 0; beat_idx = 0; exp_outst = 0; exp_err = 0;
    exp_rv = 1'b0; exp_rid = '0; exp_rresp = '0; prev_aw_stall = 1'b0; prev_aw = '0;
    w_hs_total = 0; w_last_total = 0; last_w_data = '0; last_w_last = 1'b0; last_w_id = '0;
  end

  // Compare, then advance the model by the handshakes that the next rising
  // edge will perform (inputs are stable at the falling edge).
  always @(negedge a_clk) begin : compare
    bit   active, aw_hs, w_hs, b_hs, cmd_hs, rsp_hs;
    cmd_t c, cur_aw;
    if (!a_resetn) begin
      check("rst_aw_valid", aw_valid, 0);
      check("rst_w_valid", w_valid, 0);
      check("rst_wd_ready", wd_ready, 0);
      check("rst_cmd_ready", cmd_ready, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_outst", outst_cnt, 0);
      check("rst_err", err_cnt, 0);
      cmd_q.delete();
      aw_idx = 0; burst_idx = 0; beat_idx = 0; exp_outst = 0; exp_err = 0;
      exp_rv = 1'b0; exp_rid = '0; exp_rresp = '0; prev_aw_stall = 1'b0;
    end else begin
      active = (aw_idx > burst_idx);
      cur_aw = '{id: aw_id, addr: aw_addr, len: aw_len, size: aw_size, burst: aw_burst};
      check("outst_cnt", outst_cnt, exp_outst);
      check("err_cnt", err_cnt, exp_err);
      check("rsp_valid", rsp_valid, exp_rv);
      if (exp_rv) begin
        check("rsp_id", rsp_id, exp_rid);
        check("rsp_resp", rsp_resp, exp_rresp);
      end
      check("b_ready", b_ready, !exp_rv || rsp_ready);
      check("aw_valid", aw_valid, cmd_q.size() > aw_idx);
      if (prev_aw_stall) check("aw_stable", cur_aw, prev_aw);
      if (active) begin
        check("w_valid_follow", w_valid, wd_valid);
        check("wd_ready_follow", wd_ready, w_ready);
      end else begin
        check("w_valid_idle", w_valid, 0);
        check("wd_ready_idle", wd_ready, 0);
      end
      check("cmd_ready_legal",
            cmd_ready && !((cmd_q.size() == aw_idx) && !active && (exp_outst < MAX_OUTST)), 0);

      aw_hs  = aw_valid && aw_ready;
      w_hs   = w_valid && w_ready;
      b_hs   = b_valid && b_ready;
      cmd_hs = cmd_valid && cmd_ready;
      rsp_hs = rsp_valid && rsp_ready;

      if (aw_hs) begin
        if (aw_idx < cmd_q.size()) begin
          c = cmd_q[aw_idx];
          check("aw_payload", cur_aw, c);
        end
        aw_idx++;
      end
      if (w_hs) begin
        check("w_after_aw", active, 1);
        if (active) begin
          c = cmd_q[burst_idx];
          check("w_id", w_id, c.id);
          check("w_last", w_last, beat_idx == int'(c.len));
          check("w_data", w_data, wd_data);
          check("w_strb", w_strb, wd_strb);
          if (beat_idx == int'(c.len)) begin
            burst_idx++;
            beat_idx = 0;
          end else begin
            beat_idx++;
          end
        end
        w_hs_total++;
        if (w_last) w_last_total++;
        last_w_data = w_data;
        last_w_last = w_last;
        last_w_id   = w_id;
      end
      prev_aw_stall = aw_valid && !aw_ready;
      prev_aw       = cur_aw;

      if (aw_hs && !b_hs)                      exp_outst++;
      else if (b_hs && !aw_hs && exp_outst > 0) exp_outst--;
      if (b_hs && b_resp != 2'b00 && exp_err < 255) exp_err++;

      if (rsp_hs) begin
        rsp_id_log.push_back(rsp_id);
        rsp_resp_log.push_back(rsp_resp);
      end
      if (b_hs) begin
        exp_rv = 1'b1; exp_rid = b_id; exp_rresp = b_resp;
      end else if (rsp_hs) begin
        exp_rv = 1'b0;
      end
      if (cmd_hs) cmd_q.push_back('{id: cmd_id, addr: cmd_addr, len: cmd_len,
                                    size: cmd_size, burst: cmd_burst});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge a_clk);
    #1;
  endtask

  task automatic send_cmd(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
    int n = 0;
    cmd_valid = 1'b1; cmd_id = id; cmd_addr = addr; cmd_len = len;
    cmd_size = size; cmd_burst = burst;
    @(negedge a_clk);
    while (!cmd_ready && n < BOUND) begin
      @(negedge a_clk);
      n++;
    end
    check("cmd_accept_timeout", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic send_beats(input int nb, input logic [31:0] base, input logic [3:0] strb,
                            input bit gap);
    for (int i = 0; i < nb; i++) begin
      int n = 0;
      if (gap && i > 0) begin
        wd_valid = 1'b0;
        tick();
      end
      wd_valid = 1'b1; wd_data = base + 32'(i); wd_strb = strb;
      @(negedge a_clk);
      while (!wd_ready && n < BOUND) begin
        @(negedge a_clk);
        n++;
      end
      check("wd_accept_timeout", wd_ready, 1);
      tick();
    end
    wd_valid = 1'b0;
  endtask

  task automatic send_b(input logic [3:0] id, input logic [1:0] resp);
    int n = 0;
    b_valid = 1'b1; b_id = id; b_resp = resp;
    @(negedge a_clk);
    while (!b_ready && n < BOUND) begin
      @(negedge a_clk);
      n++;
    end
    check("b_accept_timeout", b_ready, 1);
    tick();
    b_valid = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int w0, l0, n0;
    repeat (3) tick();
    check("reset_b_ready", b_ready, 1);
    a_resetn = 1'b1;
    tick(); tick();

    // Single beat.
    send_cmd(4'd0, 32'h0, 4'd0, 3'd2, 2'd1);
    send_beats(1, 32'hA5A5_A5A5, 4'hF, 1'b0);
    check("t1_w_data", last_w_data, 32'hA5A5_A5A5);
    check("t1_w_last", last_w_last, 1);
    check("t1_w_id", last_w_id, 0);
    check("t1_outst", outst_cnt, 1);
    send_b(4'd0, 2'b00);
    tick();
    check("t1_rsp_id", rsp_id_log[$], 0);
    check("t1_rsp_resp", rsp_resp_log[$], 0);
    check("t1_err", err_cnt, 0);
    check("t1_outst_done", outst_cnt, 0);

    // Four-beat burst with gaps in the data stream.
    w0 = w_hs_total; l0 = w_last_total;
    send_cmd(4'd3, 32'h100, 4'd3, 3'd2, 2'd1);
    send_beats(4, 32'h1000, 4'hF, 1'b1);
    check("t2_beats", w_hs_total - w0, 4);
    check("t2_last_count", w_last_total - l0, 1);
    check("t2_back_idle", cmd_ready, 1);
    send_b(4'd3, 2'b00);
    tick();

    // AW backpressure: data offered but must wait for the AW handshake.
    aw_ready = 1'b0;
    send_cmd(4'd1, 32'h200, 4'd1, 3'd2, 2'd1);
    wd_valid = 1'b1; wd_data = 32'h2000; wd_strb = 4'hF;
    for (int i = 0; i < 5; i++) begin
      check("t3_aw_valid", aw_valid, 1);
      check("t3_aw_addr", aw_addr, 32'h200);
      check("t3_aw_len", aw_len, 1);
      check("t3_wd_ready", wd_ready, 0);
      tick();
    end
    aw_ready = 1'b1;
    w0 = w_hs_total;
    send_beats(2, 32'h2000, 4'h3, 1'b0);
    check("t3_beats", w_hs_total - w0, 2);
    send_b(4'd1, 2'b00);
    tick();

    // Outstanding limit with B withheld.
    for (int k = 0; k < 4; k++) begin
      send_cmd(4'(10 + k), 32'(k * 16), 4'd0, 3'd2, 2'd1);
      send_beats(1, 32'(k), 4'hF, 1'b0);
    end
    tick();
    check("t4_outst_full", outst_cnt, 4);
    check("t4_cmd_blocked", cmd_ready, 0);
    cmd_valid = 1'b1; cmd_id = 4'd14; cmd_addr = 32'h40; cmd_len = 4'd0;
    cmd_size = 3'd2; cmd_burst = 2'd1;
    for (int i = 0; i < 3; i++) begin
      check("t4_cmd_held", cmd_ready, 0);
      tick();
    end
    send_b(4'd10, 2'b00);
    check("t4_ready_back", cmd_ready, 1);
    send_cmd(4'd14, 32'h40, 4'd0, 3'd2, 2'd1);
    send_beats(1, 32'h44, 4'hF, 1'b0);
    send_b(4'd11, 2'b00);
    send_cmd(4'd15, 32'h50, 4'd0, 3'd2, 2'd1);
    send_beats(1, 32'h55, 4'hF, 1'b0);
    check("t4_outst_full2", outst_cnt, 4);
    send_b(4'd12, 2'b00);
    send_b(4'd13, 2'b00);
    send_b(4'd14, 2'b00);
    send_b(4'd15, 2'b00);
    tick();
    check("t4_outst_drained", outst_cnt, 0);

    // Error responses.
    send_cmd(4'd5, 32'hFFFF_0000, 4'd0, 3'd2, 2'd1);
    send_beats(1, 32'h5, 4'hF, 1'b0);
    send_cmd(4'd6, 32'h0000_0003, 4'd0, 3'd2, 2'd3);
    send_beats(1, 32'h6, 4'h1, 1'b0);
    send_b(4'd5, 2'b11);
    tick();
    check("t5_rsp_id_decerr", rsp_id_log[$], 5);
    check("t5_rsp_decerr", rsp_resp_log[$], 2'b11);
    send_b(4'd6, 2'b10);
    tick();
    check("t5_rsp_id_slverr", rsp_id_log[$], 6);
    check("t5_rsp_slverr", rsp_resp_log[$], 2'b10);
    check("t5_err_cnt", err_cnt, 2);

    // Response backpressure with two Bs (nothing outstanding).
    rsp_ready = 1'b0;
    b_valid = 1'b1; b_id = 4'd7; b_resp = 2'b00;
    tick();
    b_id = 4'd8; b_resp = 2'b10;
    for (int i = 0; i < 3; i++) begin
      check("t6_b_blocked", b_ready, 0);
      check("t6_rsp_held", rsp_id, 7);
      tick();
    end
    n0 = rsp_id_log.size();
    rsp_ready = 1'b1;
    tick();
    b_valid = 1'b0;
    tick();
    check("t6_rsp_count", rsp_id_log.size() - n0, 2);
    check("t6_first_id", rsp_id_log[n0], 7);
    check("t6_second_id", rsp_id_log[n0 + 1], 8);
    check("t6_second_resp", rsp_resp_log[n0 + 1], 2'b10);
    check("t6_err_cnt", err_cnt, 3);
    check("t6_outst_zero", outst_cnt, 0);

    // Reset in the middle of an 8-beat burst.
    send_cmd(4'd9, 32'h300, 4'd7, 3'd2, 2'd1);
    send_beats(2, 32'h3000, 4'hF, 1'b0);
    check("t7_outst_before", outst_cnt, 1);
    wd_valid = 1'b1;
    a_resetn = 1'b0;
    #1;
    check("t7_aw_valid", aw_valid, 0);
    check("t7_w_valid", w_valid, 0);
    check("t7_wd_ready", wd_ready, 0);
    check("t7_rsp_valid", rsp_valid, 0);
    check("t7_outst", outst_cnt, 0);
    check("t7_err", err_cnt, 0);
    tick(); tick();
    a_resetn = 1'b1;
    wd_valid = 1'b0;
    tick(); tick();
    send_cmd(4'd2, 32'h80, 4'd0, 3'd2, 2'd1);
    send_beats(1, 32'hDEAD_BEEF, 4'hF, 1'b0);
    check("t7_recover_data", last_w_data, 32'hDEAD_BEEF);
    send_b(4'd2, 2'b00);
    tick();
    check("t7_recover_outst", outst_cnt, 0);

    // Error counter saturation.
    b_valid = 1'b1; b_id = 4'd1; b_resp = 2'b10;
    repeat (260) tick();
    b_valid = 1'b0;
    tick();
    check("t8_err_saturate", err_cnt, 8'd255);

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi_wr_master.md
Name: axi_wr_master

Overview:
- AXI write-channel master that turns a simple command + data-stream interface into AW, W and B channel traffic.
- Sits directly upstream of AXI_top's slave port and drives its aw_*/w_*/b_* channels.
- Replaces hand-driven channel stimulus with a reusable, protocol-correct initiator.
- Collects B responses, returns them to the requester and counts error responses.

Parameters:
- MAX_OUTST, 4, maximum AW handshakes without a matching B handshake (1..15).
- ID_W, 4, width of all ID fields.
- ADDR_W, 32, address width.
- DATA_W, 32, data width; strobe width is DATA_W/8.

Ports:
- a_clk  in  1  clock
- a_resetn  in  1  asynchronous active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_id  in  ID_W  transaction ID
- cmd_addr  in  ADDR_W  start address
- cmd_len  in  4  beats minus 1
- cmd_size  in  3  bytes per beat, log2
- cmd_burst  in  2  burst type
- wd_valid  in  1  write data beat offered
- wd_ready  out  1  write data beat accepted
- wd_data  in  DATA_W  beat data
- wd_strb  in  DATA_W/8  beat strobes
- aw_id, aw_addr, aw_len, aw_size, aw_burst  out  ID_W/ADDR_W/4/3/2  AW payload
- aw_valid  out  1  AW valid
- aw_ready  in  1  AW ready
- w_id, w_data, w_strb, w_last  out  ID_W/DATA_W/DATA_W/8/1  W payload
- w_valid  out  1  W valid
- w_ready  in  1  W ready
- b_id, b_resp  in  ID_W/2  B payload
- b_valid  in  1  B valid
- b_ready  out  1  B ready
- rsp_valid  out  1  response to requester
- rsp_ready  in  1  requester accepts response
- rsp_id, rsp_resp  out  ID_W/2  response payload
- outst_cnt  out  4  transactions currently outstanding
- err_cnt  out  8  non-OKAY B responses, saturating at 255

Behaviour:
- One clock (a_clk); reset is asynchronous and active-low (a_resetn).
- Reset values:
  - State = IDLE; aw_valid, w_valid, rsp_valid, cmd_ready, wd_ready = 0.
  - All payload registers, outst_cnt, err_cnt and beat counter = 0.
  - b_ready = 1.
- FSM states: IDLE, ADDR, DATA.
  - IDLE: cmd_ready = (outst_cnt < MAX_OUTST). On cmd handshake, latch all cmd fields into the AW registers and w_id, load beat_cnt = cmd_len, go to ADDR. aw_valid = 1 from the next cycle.
  - ADDR: aw_valid held high with stable payload until aw_ready. On handshake, aw_valid drops next cycle; go to DATA.
  - DATA:
    - w_valid = wd_valid; wd_ready = w_ready; w_data/w_strb pass through combinationally; w_id = latched id; w_last = (beat_cnt == 0).
    - Each W handshake decrements beat_cnt.
    - The handshake with w_last = 1 returns to IDLE. The next cmd can be accepted in that IDLE cycle at the earliest.
  - Outside DATA: w_valid = 0, wd_ready = 0.
- W never precedes its AW. Transactions issue strictly in command order and never interleave.
- Outstanding count:
  - +1 on AW handshake, -1 on B handshake; both in the same cycle leaves it unchanged.
  - Never exceeds MAX_OUTST.
  - A B arriving while outst_cnt = 0 is still accepted and forwarded; the counter holds at 0.
- Response path:
  - b_ready = !rsp_valid || rsp_ready.
  - On B handshake, register b_id/b_resp into rsp_id/rsp_resp and set rsp_valid next cycle.
  - rsp_valid clears after the rsp handshake unless a new B is captured in the same cycle.
  - Response latency is 1 cycle.
- err_cnt increments on every B handshake with b_resp != OKAY (2'b00) and saturates at 255.
- No local legality checking: illegal size, burst or alignment is forwarded unchanged and the slave's SLVERR/DECERR response is returned.
- Reset mid-transaction: all valids drop immediately (asynchronously), counters clear, and the partial burst is abandoned.

Decomposition:
- Shared package axi_pkg holds:
  - Response codes OKAY/EXOKAY/SLVERR/DECERR.
  - Burst codes FIXED/INCR/WRAP.
  - The FSM state enum.
- Optional sub-module axi_rsp_reg is the single-entry B to rsp register with ready/valid. Everything else stays in one module.

Test Plan:
- Single beat: cmd id=0, addr=0, len=0, size=2, burst=1; one wd beat 32'hA5A5_A5A5 strb 4'hF -> one AW, then one W with w_last=1, w_id=0; rsp_id=0, rsp_resp=OKAY; err_cnt=0.
- Burst length 4: cmd id=3, len=3; 4 beats with wd_valid toggling every other cycle -> exactly 4 W handshakes, w_last only on the 4th; FSM returns to IDLE.
- Backpressure: aw_ready held 0 for 5 cycles -> aw_valid and AW payload stable, wd_ready=0 throughout; W starts only after the AW handshake.
- Outstanding limit: MAX_OUTST=4, b_valid held 0, 6 single-beat cmds -> cmd_ready low after the 4th AW, outst_cnt=4; the first B restores cmd_ready.
- Errors: slave returns DECERR for id=5 and SLVERR for id=6 -> rsp_resp 2'b11 and 2'b10 with matching ids; err_cnt=2.
- rsp_ready held 0 with two Bs arriving -> the first is held in rsp, b_ready=0 for the second, and no response is lost after rsp_ready rises. Reset asserted mid-burst -> all valids 0 and outst_cnt=0.
